// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready holding register and framing/overrun pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx #(
  parameter int unsigned CLKFREQ      = 100_000_000,
  parameter int unsigned BAUDRATE     = 9600,
  parameter int unsigned CLKS_PER_BIT = CLKFREQ / BAUDRATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uartRx,
  output logic [7:0] data,
  output logic       dataValid,
  input  logic       dataReady,
  output logic       busy,
  output logic       framingErr,
  output logic       overrun
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] OFS = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] OFS = CNT_W'(0);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state;
  logic             rx_meta;
  logic             rxS;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             commit;
  logic             half_hit;
  logic             full_hit;
  logic             bit_val;

  // Two-flop synchronizer; idle-high reset avoids a false start after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxS     <= 1'b1;
    end else begin
      rx_meta <= uartRx;
      rxS     <= rx_meta;
    end
  end

  assign half_hit = (cnt == HALF_C + OFS);
  assign full_hit = (cnt == FULL_C + OFS);

`ifdef UART_RX_MAJORITY_EN
  logic             s_early;
  logic             s_mid;
  logic [CNT_W-1:0] centre;

  // Capture the two samples preceding the decision point.
  assign centre = (state == START) ? HALF_C : FULL_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (cnt == centre - CNT_W'(1)) s_early <= rxS;
      if (cnt == centre)             s_mid   <= rxS;
    end
  end

  assign bit_val = (s_early & s_mid) | (s_early & rxS) | (s_mid & rxS);
`else
  assign bit_val = rxS;
`endif

  // Frame FSM plus holding register; commit lands one cycle after the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      commit     <= 1'b0;
      data       <= 8'h00;
      dataValid  <= 1'b0;
      busy       <= 1'b0;
      framingErr <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      framingErr <= 1'b0;
      overrun    <= 1'b0;
      commit     <= 1'b0;

      if (commit) begin
        if (!dataValid || dataReady) begin
          data      <= shift;
          dataValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dataValid && dataReady) begin
        dataValid <= 1'b0;
      end

      cnt <= (state == IDLE) ? '0 : cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (!rxS) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (half_hit) begin
            cnt <= '0;
            if (!bit_val) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (full_hit) begin
            cnt            <= '0;
            shift[bit_idx] <= bit_val;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (full_hit) begin
            cnt <= '0;
            if (bit_val) begin
              commit <= 1'b1;
              state  <= IDLE;
              busy   <= 1'b0;
            end else begin
              framingErr <= 1'b1;
              state      <= BRK;
            end
          end
        end
        BRK: begin
          // Hold off re-arming until the line break ends.
          if (rxS) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: directed frames, handshake,
// overrun, framing error/break, glitch rejection and mid-frame reset.
module tb_uart_rx;
  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uartRx;
  logic [7:0] data;
  logic       dataValid;
  logic       dataReady;
  logic       busy;
  logic       framingErr;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(.CLKFREQ(160), .BAUDRATE(10), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uartRx     (uartRx),
    .data       (data),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .busy       (busy),
    .framingErr (framingErr),
    .overrun    (overrun)
  );

  int         cmp_n = 0;
  int         err_n = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         dv_rise = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       dv_d = 1'b0;
  logic       fe_d = 1'b0;
  logic       ov_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected byte on every accepted handshake and tallies pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dataValid && !dv_d) dv_rise++;
      if (framingErr) begin
        fe_cnt++;
        check("framingErr_width", 32'(fe_d), 32'd0);
      end
      if (overrun) begin
        ov_cnt++;
        check("overrun_width", 32'(ov_d), 32'd0);
      end
      if (dataValid && dataReady) begin
        if (exp_q.size() == 0) begin
          cmp_n++;
          err_n++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none", data);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_byte", 32'(data), 32'(exp_b));
        end
      end
    end
    dv_d = dataValid;
    fe_d = framingErr;
    ov_d = overrun;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uartRx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      tick(CPB);
    end
    uartRx = stop_bit;
    tick(CPB);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dataValid"},  32'(dataValid),  32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_data"},       32'(data),       32'h00);
    check({tag, "_framingErr"}, 32'(framingErr), 32'd0);
    check({tag, "_overrun"},    32'(overrun),    32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    uartRx    = 1'b1;
    dataReady = 1'b0;
    tick(3);
    @(negedge clk);
    check_reset_outputs("reset");
    tick(1);
    rst_n = 1'b1;
    tick(5);

    // 0xA5 with consumer always ready
    dataReady = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(4);
    @(negedge clk);
    check("t1_dataValid", 32'(dataValid), 32'd0);
    check("t1_dv_rise", 32'(dv_rise), 32'd1);
    check("t1_fe", 32'(fe_cnt), 32'd0);
    check("t1_ov", 32'(ov_cnt), 32'd0);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // 0x3C held until the consumer accepts
    tick(1);
    dataReady = 1'b0;
    send_frame(8'h3C, 1'b1);
    tick(20);
    @(negedge clk);
    check("t2_dataValid_held", 32'(dataValid), 32'd1);
    check("t2_data_held", 32'(data), 32'h3C);
    exp_q.push_back(8'h3C);
    tick(1);
    dataReady = 1'b1;
    tick(2);
    @(negedge clk);
    check("t2_dataValid_drop", 32'(dataValid), 32'd0);
    check("t2_queue", 32'(exp_q.size()), 32'd0);

    // Back-to-back 0x11, 0x22 with consumer stalled -> overrun
    tick(1);
    dataReady = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    @(negedge clk);
    check("t3_ov", 32'(ov_cnt), 32'd1);
    check("t3_data_retained", 32'(data), 32'h11);
    check("t3_dataValid", 32'(dataValid), 32'd1);
    exp_q.push_back(8'h11);
    tick(1);
    dataReady = 1'b1;
    tick(2);
    @(negedge clk);
    check("t3_dataValid_drop", 32'(dataValid), 32'd0);
    check("t3_queue", 32'(exp_q.size()), 32'd0);

    // 0x55 with low stop bit followed by a long break
    tick(1);
    send_frame(8'h55, 1'b0);
    tick(40 * CPB);
    @(negedge clk);
    check("t4_fe", 32'(fe_cnt), 32'd1);
    check("t4_busy_break", 32'(busy), 32'd1);
    check("t4_dataValid", 32'(dataValid), 32'd0);
    check("t4_dv_rise", 32'(dv_rise), 32'd3);
    tick(1);
    uartRx = 1'b1;
    tick(5);
    @(negedge clk);
    check("t4_busy_release", 32'(busy), 32'd0);
    exp_q.push_back(8'h0F);
    tick(1);
    send_frame(8'h0F, 1'b1);
    tick(4);
    @(negedge clk);
    check("t4_queue", 32'(exp_q.size()), 32'd0);
    check("t4_fe_after", 32'(fe_cnt), 32'd1);

    // Four-clock glitch is rejected at the start-bit centre
    tick(1);
    uartRx = 1'b0;
    tick(4);
    uartRx = 1'b1;
    @(negedge clk);
    check("t5_busy_rise", 32'(busy), 32'd1);
    tick(20);
    @(negedge clk);
    check("t5_busy_fall", 32'(busy), 32'd0);
    check("t5_dv_rise", 32'(dv_rise), 32'd4);
    check("t5_fe", 32'(fe_cnt), 32'd0 + 32'd1);

    // Reset during bit 3 of 0xFF, then 0x81
    tick(1);
    uartRx = 1'b0;
    tick(CPB);
    uartRx = 1'b1;
    tick(3 * CPB + CPB / 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(3);
    rst_n = 1'b1;
    tick(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(4);
    @(negedge clk);
    check("t6_queue", 32'(exp_q.size()), 32'd0);
    check("t6_dv_rise", 32'(dv_rise), 32'd5);
    check("t6_ov", 32'(ov_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
